// File: rtl/prbs_checker.sv
// PRBS stream checker: self-synchronises a local Fibonacci LFSR to the received
// bit stream, then flywheels and flags every bit that departs from the prediction.
//
// state     | meaning
// ST_SEARCH | loading received bits into r, counting consecutive correct predictions
// ST_LOCKED | r advances on its own prediction; mismatches are counted and windowed
module prbs_checker #(
  parameter int unsigned     LN          = 8,
  parameter logic [LN-1:0]   TAPS        = 8'h2d,
  parameter int unsigned     LOCK_COUNT  = 16,
  parameter int unsigned     LOSS_ERRORS = 4,
  parameter int unsigned     WINDOW      = 64,
  parameter int unsigned     CW          = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic          i_bit,
  input  logic          i_clear,
  output logic          o_locked,
  output logic          o_err,
  output logic [CW-1:0] o_errors,
  output logic [CW-1:0] o_bits
);

  localparam int unsigned FW = $clog2(LN + 1);
  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned EW = $clog2(LOSS_ERRORS + 1);

  localparam logic [FW-1:0] FILL_FULL  = FW'(LN);
  localparam logic [MW-1:0] MATCH_LOCK = MW'(LOCK_COUNT);
  localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
  localparam logic [EW-1:0] ERR_LOSS   = EW'(LOSS_ERRORS);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t        state_q,   state_d;
  logic [LN-1:0] r_q,       r_d;
  logic [FW-1:0] fill_q,    fill_d;
  logic [MW-1:0] match_q,   match_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [EW-1:0] win_err_q, win_err_d;
  logic          err_q,     err_d;
  logic [CW-1:0] bits_q,    bits_d;
  logic [CW-1:0] errors_q,  errors_d;

  logic          pred;
  logic          miss;
  logic          bit_evt;
  logic          err_evt;
  logic [MW-1:0] match_inc;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Prediction of the next stream bit from the last LN bits (r[0] is the oldest).
  assign pred      = ^(r_q & TAPS);
  assign miss      = i_bit != pred;
  assign match_inc = match_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    fill_d    = fill_q;
    match_d   = match_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    err_d     = 1'b0;
    bit_evt   = 1'b0;
    err_evt   = 1'b0;

    if (i_ce) begin
      if (state_q == ST_SEARCH) begin
        r_d = {i_bit, r_q[LN-1:1]};
        if (fill_q != FILL_FULL) begin
          fill_d = fill_q + 1'b1;
        end else if (!miss && (r_q != '0)) begin
          match_d = match_inc;
          if (match_inc == MATCH_LOCK) begin
            state_d   = ST_LOCKED;
            win_cnt_d = '0;
            win_err_d = '0;
          end
        end else begin
          // An all-zero register trivially predicts zeros, so it never counts.
          match_d = '0;
        end
      end else begin
        r_d     = {pred, r_q[LN-1:1]};
        bit_evt = 1'b1;
        err_evt = miss;
        err_d   = miss;
        if (miss && ((win_err_q + 1'b1) == ERR_LOSS)) begin
          state_d = ST_SEARCH;
          r_d     = '0;
          fill_d  = '0;
          match_d = '0;
        end else if (win_cnt_q == WIN_LAST) begin
          win_cnt_d = '0;
          win_err_d = '0;
        end else begin
          win_cnt_d = win_cnt_q + 1'b1;
          if (miss) begin
            win_err_d = win_err_q + 1'b1;
          end
        end
      end
    end

    // A clear coinciding with an event leaves that event counted.
    bits_d = bits_q;
    if (i_clear) begin
      bits_d = CW'(bit_evt);
    end else if (bit_evt) begin
      bits_d = sat_inc(bits_q);
    end

    errors_d = errors_q;
    if (i_clear) begin
      errors_d = CW'(err_evt);
    end else if (err_evt) begin
      errors_d = sat_inc(errors_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_SEARCH;
      r_q       <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      err_q     <= 1'b0;
      bits_q    <= '0;
      errors_q  <= '0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      err_q     <= err_d;
      bits_q    <= bits_d;
      errors_q  <= errors_d;
    end
  end

  assign o_locked = (state_q == ST_LOCKED);
  assign o_err    = err_q;
  assign o_bits   = bits_q;
  assign o_errors = errors_q;

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side companion to the Fibonacci LFSR generator; consumes its serial bit stream, one bit per i_ce.
- Self-synchronises a local LFSR to the incoming stream, then flywheels and flags every bit that differs from the predicted sequence.
- Used as the sink on PRBS loopback and channel tests; reports lock status, per-bit error strobe and saturating bit/error counters.

Parameters:
- LN, 8, LFSR length / polynomial degree; must match the generator.
- TAPS, 8'h2d, LN-bit tap mask; must match the generator.
- LOCK_COUNT, 16, consecutive correct predictions required to declare lock.
- LOSS_ERRORS, 4, errors within one window that force loss of lock.
- WINDOW, 64, length in locked bits of the loss-of-lock error window.
- CW, 16, width of the bit and error counters.

Ports:
- i_clk  input  1  clock
- i_reset  input  1  synchronous, active-high reset
- i_ce  input  1  qualifies i_bit; one stream bit per cycle with i_ce high
- i_bit  input  1  received stream bit (generator o_bit)
- i_clear  input  1  synchronous clear of o_bits and o_errors
- o_locked  output  1  high while in LOCKED
- o_err  output  1  one-cycle strobe: the last accepted bit mismatched while locked
- o_errors  output  CW  saturating count of errors while locked
- o_bits  output  CW  saturating count of bits compared while locked

Behaviour:
- Reset (i_clk, i_reset synchronous, active-high): state SEARCH, shift register r=0, fill count 0, match count 0, window count and window error count 0. All outputs 0.
- Reset mid-operation: everything returns to reset values; counters are cleared; a new search starts.
- Shift register r[LN-1:0]: the newest bit enters r[LN-1] and r shifts right. The prediction is p = ^(r & TAPS). This follows generator recursion b[n+LN] = XOR of b[n+i] over all i where TAPS[i]=1.
- i_ce low: no state changes and o_err=0.

SEARCH:
- Each i_ce: r <= {i_bit, r[LN-1:1]}.
- The first LN accepted bits only fill r; fill count saturates at LN.
- Once filled, each bit is compared with p before shifting.
  - Match with r != 0: match count increments.
  - Mismatch, or r == 0: match count resets to 0. This prevents locking on an all-zero stream.
- When the match count reaches LOCK_COUNT, go to LOCKED; o_locked rises on the next clock edge.
- o_err is always 0 in SEARCH, and neither counter increments.

LOCKED (flywheel):
- Each i_ce: r <= {p, r[LN-1:1]}. The received bit is never loaded, so a single channel error causes exactly one o_err.
- o_bits increments each accepted bit.
- If i_bit != p:
  - o_err=1 on the next cycle; o_err has one cycle latency from the accepted bit.
  - o_errors increments.
  - The window error count increments.
- Window count runs 0..WINDOW-1, starting at 0 on entry to LOCKED. The bit at count WINDOW-1 belongs to the current window; afterwards the window error count clears.
- If the window error count reaches LOSS_ERRORS:
  - Return to SEARCH; o_locked falls on the same edge that raises o_err for that error.
  - Reset fill and match counts to 0 and r to 0.
  - Counters hold their values.

Counters:
- o_bits and o_errors saturate at all-ones; they do not wrap.
- i_clear takes priority. If a counting event occurs in the same cycle, the counter loads 1; otherwise it loads 0.
- i_clear does not affect lock state.

Test Plan:
- Generator LN=8, TAPS=8'h2d, fill 8'h01, i_ce always high, fed directly. Required response:
  - o_locked rises the clock after the 24th accepted bit (8 fill + 16 matches).
  - o_err stays 0 over the next 1000 bits.
  - o_bits = 1000 after 1000 locked bits.
- Same stream, bit 100 after lock inverted. Required response:
  - Exactly one o_err pulse, one cycle after that bit.
  - o_errors=1; o_locked stays high.
- 4 inversions at locked bits 10, 20, 30, 40 (same window). Required response:
  - o_locked falls with the 4th o_err.
  - o_errors=4.
  - Relock 24 bits later.
- 3 inversions at locked bits 60, 61, 62 plus one at bit 70 (next window). Required response: lock held; o_errors=4.
- All-zero input for 200 bits. Required response: o_locked never asserts.
- Counter edge cases:
  - Random i_ce (~50% duty): lock point and error count are identical to the continuous case.
  - i_clear coincident with an error strobe: o_errors=1 the next cycle.
  - CW=4 with 20 errors: o_errors saturates at 15.
  - i_reset pulsed while locked: all outputs 0 the next cycle; relock after 24 bits.
